dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Miss/write-through sequencer for the M-stage data cache.
- Detects read misses and stores on the M-stage access, and stalls the pipeline while it works.
- On a read miss, refills one cache line from backing memory word by word, then marks it valid.
- Cache policy: direct-mapped, write-through, no-write-allocate. Sits between the M stage, the cache array and the single backing-memory port.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..16.
- MEM_LAT_MAX, 255, watchdog limit in cycles waiting for mem_ready/mem_rvalid; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ReqValid  in  1  M-stage instruction is a load or store
- ReqWrite  in  1  1=store, 0=load
- ReqAddr  in  32  byte address (ALUResultM)
- ReqWData  in  32  store data (WriteDataM)
- ReqMemType  in  1  1=word, 0=byte
- Hit  in  1  cache tag match and valid for ReqAddr (combinational from array)
- StallM  out  1  freeze F/D/E/M pipeline registers
- FillWE  out  1  write one word into the cache data array
- FillAddr  out  32  word address being filled
- FillData  out  32  fill word
- FillDone  out  1  one-cycle pulse: set tag/valid for the line at FillAddr
- mem_req  out  1  backing-memory request valid
- mem_we  out  1  request is a write
- mem_addr  out  32  word-aligned request address
- mem_wdata  out  32  write data, byte lane replicated for byte stores
- mem_be  out  4  byte enables
- mem_ready  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- MemErr  out  1  sticky watchdog timeout flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE, beat counter=0, wait counter=0. All outputs 0, including StallM and MemErr.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- StallM (combinational):
  - 1 in RD_REQ, RD_WAIT and WR_REQ.
  - In IDLE, 1 when ReqValid && (ReqWrite || !Hit).
  - 0 in DONE.
- IDLE:
  - ReqValid && !ReqWrite && Hit: no action, zero latency.
  - ReqValid && !ReqWrite && !Hit: latch line base = ReqAddr with low log2(LINE_WORDS)+2 bits cleared; beat=0; go to RD_REQ.
  - ReqValid && ReqWrite: latch address, data and byte enables; go to WR_REQ. The cache array performs its own hit-write in parallel.
- RD_REQ:
  - mem_req=1, mem_we=0, mem_be=4'hF, mem_addr = base + 4*beat.
  - Hold all outputs stable until mem_ready=1, then go to RD_WAIT.
- RD_WAIT:
  - On mem_rvalid: FillWE=1, FillAddr = base + 4*beat, FillData = mem_rdata.
  - If beat == LINE_WORDS-1: FillDone=1 in the same cycle, go to DONE.
  - Otherwise beat++, go to RD_REQ.
  - Exactly one request outstanding at any time.
- WR_REQ:
  - mem_req=1, mem_we=1, mem_addr = word-aligned ReqAddr.
  - Word store: mem_be=4'hF, mem_wdata = ReqWData.
  - Byte store: mem_be = 1<<ReqAddr[1:0], mem_wdata = {4{ReqWData[7:0]}}.
  - On mem_ready, go to DONE.
- DONE:
  - Exactly one cycle, StallM=0; the M-stage instruction advances. Reads now hit and data comes from the cache.
  - The request present in DONE is not re-evaluated. Next state is IDLE unconditionally.
- Read-miss latency: 1 + LINE_WORDS*(request + response) cycles of stall.
- Watchdog (MEM_LAT_MAX>0):
  - Wait counter increments each cycle in RD_REQ/RD_WAIT/WR_REQ without progress.
  - Cleared on mem_ready or mem_rvalid.
  - Reaching MEM_LAT_MAX: set MemErr, drop mem_req, abort to DONE without FillDone, so the line stays invalid.
  - MemErr clears only on reset.
- mem_rvalid outside RD_WAIT is ignored.
- Reset mid-refill: outputs clear immediately. No FillDone was issued, so the partial line stays invalid. Beats already written are harmless.
- mem_ready and mem_rvalid in the same cycle in RD_REQ: only the accept is taken. The response is expected in RD_WAIT.

Test Plan:
- Load hit: ReqValid=1, ReqWrite=0, Hit=1 -> StallM=0 that cycle, mem_req never asserts.
- Read miss at 0x0000_1234, LINE_WORDS=4, memory answers ready+1cycle rvalid:
  - Reads issued to 0x1230, 0x1234, 0x1238, 0x123C in order.
  - Four FillWE pulses; FillDone coincides with the 0x123C fill.
  - StallM high until DONE; DONE lasts one cycle.
- Byte store of 0xA5 to 0x0000_0102 -> mem_we=1, mem_addr=0x100, mem_be=4'b0100, mem_wdata=0xA5A5A5A5; StallM released in DONE.
- Backpressure: mem_ready held low 10 cycles in RD_REQ -> mem_addr, mem_req and mem_be stable throughout; StallM stays 1.
- rst_n pulsed low during beat 2 of a refill -> all outputs 0 asynchronously, FillDone never pulses; state IDLE after release.
- Watchdog with MEM_LAT_MAX=8 and mem_ready stuck low -> MemErr=1 after 8 cycles, no FillDone, one DONE cycle, then IDLE.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Miss / write-through sequencer for the M-stage data cache.
// Refills a direct-mapped line word by word on a read miss and forwards every store to memory.
module dcache_ctrl #(
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LAT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic        ReqMemType,
  input  logic        Hit,
  output logic        StallM,
  output logic        FillWE,
  output logic [31:0] FillAddr,
  output logic [31:0] FillData,
  output logic        FillDone,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        MemErr
);

  localparam int BW = $clog2(LINE_WORDS);
  localparam int WW = (MEM_LAT_MAX > 1) ? $clog2(MEM_LAT_MAX + 1) : 1;
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS) * 32'd4 - 32'd1;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic          stall_c;
  logic          busy, progress, timeout;
  logic [31:0]   beat_addr;

  assign beat_addr = base_q + {{(30-BW){1'b0}}, beat_q, 2'b00};
  assign busy      = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);
  assign progress  = (state_q == RD_WAIT) ? mem_rvalid : mem_ready;

  if (MEM_LAT_MAX > 0) begin : g_wd
    assign timeout = busy && !progress && (wait_q == WW'(MEM_LAT_MAX - 1));
  end else begin : g_nowd
    assign timeout = 1'b0;
  end

  // Stall is gated by reset so every output reads 0 while rst_n is low,
  // even with a miss presented on the request inputs.
  assign StallM = stall_c & rst_n;
  assign MemErr = err_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    err_d     = err_q;
    stall_c   = 1'b0;
    FillWE    = 1'b0;
    FillAddr  = '0;
    FillData  = '0;
    FillDone  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;

    case (state_q)
      IDLE: begin
        stall_c = ReqValid && (ReqWrite || !Hit);
        wait_d  = '0;
        if (ReqValid && ReqWrite) begin
          addr_d  = ReqAddr;
          be_d    = ReqMemType ? 4'hF : (4'b0001 << ReqAddr[1:0]);
          wdata_d = ReqMemType ? ReqWData : {4{ReqWData[7:0]}};
          state_d = WR_REQ;
        end else if (ReqValid && !Hit) begin
          base_d  = ReqAddr & ~LINE_MASK;
          beat_d  = '0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        stall_c  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = beat_addr;
        mem_be   = 4'hF;
        if (mem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        stall_c = 1'b1;
        if (mem_rvalid) begin
          FillWE   = 1'b1;
          FillAddr = beat_addr;
          FillData = mem_rdata;
          if (beat_q == BW'(LINE_WORDS - 1)) begin
            FillDone = 1'b1;
            state_d  = DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        stall_c   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_be    = be_q;
        mem_wdata = wdata_q;
        if (mem_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (busy) begin
      if (progress) begin
        wait_d = '0;
      end else if (timeout) begin
        wait_d  = '0;
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: one default instance plus one with an 8-cycle watchdog.
module tb_dcache_ctrl;

  logic        clk, rst_n, rst_n_wd;
  logic        ReqValid, ReqWrite, ReqMemType, Hit;
  logic [31:0] ReqAddr, ReqWData;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        StallM, FillWE, FillDone, mem_req, mem_we, MemErr;
  logic [31:0] FillAddr, FillData, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        w_StallM, w_FillWE, w_FillDone, w_mem_req, w_mem_we, w_MemErr;
  logic [31:0] w_FillAddr, w_FillData, w_mem_addr, w_mem_wdata;
  logic [3:0]  w_mem_be;

  int          n_cmp, n_err;
  logic        pending;
  logic [31:0] pend_addr;

  dcache_ctrl #(.LINE_WORDS(4), .MEM_LAT_MAX(255)) dut (
    .clk(clk), .rst_n(rst_n), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqMemType(ReqMemType), .Hit(Hit),
    .StallM(StallM), .FillWE(FillWE), .FillAddr(FillAddr), .FillData(FillData),
    .FillDone(FillDone), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .MemErr(MemErr)
  );

  dcache_ctrl #(.LINE_WORDS(4), .MEM_LAT_MAX(8)) dut_wd (
    .clk(clk), .rst_n(rst_n_wd), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqMemType(ReqMemType), .Hit(Hit),
    .StallM(w_StallM), .FillWE(w_FillWE), .FillAddr(w_FillAddr), .FillData(w_FillData),
    .FillDone(w_FillDone), .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_be(w_mem_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .MemErr(w_MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    ReqValid = 0; ReqWrite = 0; ReqMemType = 1; Hit = 0;
    ReqAddr = '0; ReqWData = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0; pending = 0; pend_addr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Memory model: accepts a request the cycle it appears, answers the next cycle.
  task automatic responder();
    mem_ready  = mem_req;
    mem_rvalid = pending;
    mem_rdata  = pending ? (32'hD000_0000 ^ pend_addr) : 32'h0;
    #1;
  endtask

  task automatic tick();
    if (mem_req && mem_ready) begin
      pending = 1; pend_addr = mem_addr;
    end else begin
      pending = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; rst_n_wd = 0;
    ReqValid = 1; Hit = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({StallM, FillWE, FillDone, mem_req, mem_we, MemErr} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 000000", {StallM, FillWE, FillDone, mem_req, mem_we, MemErr}); end
    n_cmp++; if ({mem_addr, mem_wdata, FillAddr, FillData, mem_be} !== 132'h0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, FillAddr, FillData, mem_be}); end
    n_cmp++; if ({w_StallM, w_FillWE, w_FillDone, w_mem_req, w_mem_we, w_MemErr} !== 6'b0) begin
      n_err++; $display("FAIL reset_wd_ctl: got %b want 000000", {w_StallM, w_FillWE, w_FillDone, w_mem_req, w_mem_we, w_MemErr}); end
    n_cmp++; if ({w_mem_addr, w_mem_wdata, w_FillAddr, w_FillData, w_mem_be} !== 132'h0) begin
      n_err++; $display("FAIL reset_wd_data: got %h want 0", {w_mem_addr, w_mem_wdata, w_FillAddr, w_FillData, w_mem_be}); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    n_cmp++; if ({StallM, mem_req} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle: got %b want 00", {StallM, mem_req}); end
  endtask

  task automatic test_load_hit();
    do_reset();
    ReqValid = 1; ReqWrite = 0; Hit = 1; ReqAddr = 32'h0000_0040;
    for (int c = 0; c < 4; c++) begin
      responder();
      n_cmp++; if ({StallM, mem_req} !== 2'b00) begin
        n_err++; $display("FAIL load_hit c=%0d: got stall/req %b want 00", c, {StallM, mem_req}); end
      tick();
    end
    ReqValid = 0;
  endtask

  task automatic test_read_miss();
    int reqs, fills, stalls;
    logic got_done;
    logic [31:0] exp;
    reqs = 0; fills = 0; stalls = 0; got_done = 0;
    do_reset();
    ReqValid = 1; ReqWrite = 0; Hit = 0; ReqMemType = 1; ReqAddr = 32'h0000_1234;
    for (int c = 0; c < 40; c++) begin
      responder();
      if (!StallM) begin got_done = 1; break; end
      stalls++;
      if (mem_req) begin
        exp = 32'h1230 + 32'(reqs * 4);
        n_cmp++; if (mem_addr !== exp || mem_we !== 1'b0 || mem_be !== 4'hF) begin
          n_err++; $display("FAIL miss_req%0d: got addr %h we %b be %h want %h 0 f", reqs, mem_addr, mem_we, mem_be, exp); end
        reqs++;
      end
      if (FillWE) begin
        exp = 32'h1230 + 32'(fills * 4);
        n_cmp++; if (FillAddr !== exp || FillData !== (32'hD000_0000 ^ exp) || FillDone !== (fills == 3)) begin
          n_err++; $display("FAIL miss_fill%0d: got %h %h done %b want %h %h done %b",
                            fills, FillAddr, FillData, FillDone, exp, 32'hD000_0000 ^ exp, fills == 3); end
        fills++;
      end else if (FillDone) begin
        n_cmp++; n_err++; $display("FAIL miss_stray_done: got FillDone 1 without FillWE want 0");
      end
      tick();
    end
    n_cmp++; if (got_done !== 1'b1 || stalls != 9) begin
      n_err++; $display("FAIL miss_latency: got done %b stalls %0d want 1 9", got_done, stalls); end
    n_cmp++; if (reqs != 4 || fills != 4) begin
      n_err++; $display("FAIL miss_counts: got reqs %0d fills %0d want 4 4", reqs, fills); end
    n_cmp++; if ({mem_req, FillWE, FillDone} !== 3'b000) begin
      n_err++; $display("FAIL miss_done_outs: got %b want 000", {mem_req, FillWE, FillDone}); end
    // A store presented in DONE must not stall there, but must stall one cycle later in IDLE.
    ReqWrite = 1; Hit = 1;
    #1;
    n_cmp++; if (StallM !== 1'b0) begin
      n_err++; $display("FAIL miss_done_stall: got %b want 0", StallM); end
    tick();
    #1;
    n_cmp++; if (StallM !== 1'b1) begin
      n_err++; $display("FAIL miss_done_1cyc: got %b want 1", StallM); end
    ReqValid = 0;
  endtask

  task automatic test_store();
    logic [31:0] v_addr  [3] = '{32'h0000_0102, 32'h0000_0203, 32'h0000_0007};
    logic [31:0] v_data  [3] = '{32'h1234_56A5, 32'hCAFE_BABE, 32'h0000_003C};
    logic        v_word  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] e_addr  [3] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0004};
    logic [3:0]  e_be    [3] = '{4'b0100, 4'b1111, 4'b1000};
    logic [31:0] e_wdata [3] = '{32'hA5A5_A5A5, 32'hCAFE_BABE, 32'h3C3C_3C3C};
    for (int v = 0; v < 3; v++) begin
      do_reset();
      ReqValid = 1; ReqWrite = 1; Hit = 1; ReqMemType = v_word[v];
      ReqAddr = v_addr[v]; ReqWData = v_data[v];
      #1;
      n_cmp++; if ({StallM, mem_req} !== 2'b10) begin
        n_err++; $display("FAIL st%0d_idle: got stall/req %b want 10", v, {StallM, mem_req}); end
      @(posedge clk); @(negedge clk);
      mem_ready = 1;
      #1;
      n_cmp++; if ({StallM, mem_req, mem_we} !== 3'b111 || mem_addr !== e_addr[v] ||
                   mem_be !== e_be[v] || mem_wdata !== e_wdata[v]) begin
        n_err++; $display("FAIL st%0d_req: got %b %h %b %h want 111 %h %b %h", v, {StallM, mem_req, mem_we},
                          mem_addr, mem_be, mem_wdata, e_addr[v], e_be[v], e_wdata[v]); end
      @(posedge clk); @(negedge clk);
      mem_ready = 0;
      #1;
      n_cmp++; if ({StallM, mem_req} !== 2'b00) begin
        n_err++; $display("FAIL st%0d_done: got stall/req %b want 00", v, {StallM, mem_req}); end
      ReqValid = 0;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ReqValid = 1; ReqWrite = 0; Hit = 0; ReqAddr = 32'h0000_4008;
    #1;
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++; if ({mem_req, mem_we, mem_be, StallM} !== 7'b1011111 || mem_addr !== 32'h4000) begin
        n_err++; $display("FAIL bp_hold c=%0d: got %b addr %h want 1011111 4000", c, {mem_req, mem_we, mem_be, StallM}, mem_addr); end
      @(posedge clk); @(negedge clk);
    end
    // Accept and an early rvalid together: only the accept counts.
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h0000_0BAD;
    #1;
    n_cmp++; if ({mem_req, FillWE} !== 2'b10) begin
      n_err++; $display("FAIL bp_accept: got req/fillwe %b want 10", {mem_req, FillWE}); end
    @(posedge clk); @(negedge clk);
    mem_ready = 0; mem_rvalid = 0;
    #1;
    n_cmp++; if ({mem_req, FillWE, StallM} !== 3'b001) begin
      n_err++; $display("FAIL bp_wait: got %b want 001", {mem_req, FillWE, StallM}); end
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    #1;
    n_cmp++; if (FillWE !== 1'b1 || FillDone !== 1'b0 || FillAddr !== 32'h4000 || FillData !== 32'h1111_2222) begin
      n_err++; $display("FAIL bp_fill: got %b %b %h %h want 1 0 4000 11112222", FillWE, FillDone, FillAddr, FillData); end
    @(posedge clk); @(negedge clk);
    mem_rvalid = 0;
    #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4004) begin
      n_err++; $display("FAIL bp_beat1: got req %b addr %h want 1 4004", mem_req, mem_addr); end
    ReqValid = 0;
  endtask

  task automatic test_reset_midfill();
    int fills;
    logic found;
    fills = 0; found = 0;
    do_reset();
    ReqValid = 1; ReqWrite = 0; Hit = 0; ReqAddr = 32'h0000_1234;
    for (int c = 0; c < 20; c++) begin
      responder();
      if (fills == 2 && mem_req) begin found = 1; break; end
      if (FillWE) fills++;
      if (FillDone) begin
        n_cmp++; n_err++; $display("FAIL mid_early_done: got FillDone 1 want 0");
      end
      tick();
    end
    n_cmp++; if (found !== 1'b1) begin
      n_err++; $display("FAIL mid_reach_beat2: got %b want 1", found); end
    rst_n = 0; mem_rvalid = 1;
    #1;
    n_cmp++; if ({StallM, FillWE, FillDone, mem_req, mem_we, MemErr} !== 6'b0 ||
                 {mem_addr, mem_wdata, FillAddr, FillData, mem_be} !== 132'h0) begin
      n_err++; $display("FAIL mid_async_clear: got %b %h want 0", {StallM, FillWE, FillDone, mem_req, mem_we, MemErr},
                        {mem_addr, mem_wdata, FillAddr, FillData, mem_be}); end
    @(posedge clk);
    #1;
    n_cmp++; if ({FillDone, FillWE, StallM} !== 3'b000) begin
      n_err++; $display("FAIL mid_in_reset: got %b want 000", {FillDone, FillWE, StallM}); end
    @(negedge clk);
    rst_n = 1; ReqValid = 0; mem_ready = 0; mem_rvalid = 0; pending = 0;
    @(posedge clk); @(negedge clk);
    #1;
    n_cmp++; if ({StallM, mem_req, FillDone} !== 3'b000) begin
      n_err++; $display("FAIL mid_idle: got %b want 000", {StallM, mem_req, FillDone}); end
    ReqValid = 1; Hit = 0;
    #1;
    n_cmp++; if (StallM !== 1'b1) begin
      n_err++; $display("FAIL mid_idle_miss: got %b want 1", StallM); end
    ReqValid = 0;
  endtask

  task automatic test_watchdog();
    @(negedge clk);
    idle_inputs();
    rst_n = 0; rst_n_wd = 0;
    @(negedge clk);
    rst_n_wd = 1;
    ReqValid = 1; ReqWrite = 0; Hit = 0; ReqAddr = 32'h0000_0808;
    #1;
    n_cmp++; if (w_StallM !== 1'b1) begin
      n_err++; $display("FAIL wd_idle: got %b want 1", w_StallM); end
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++; if ({w_mem_req, w_StallM, w_MemErr, w_FillDone} !== 4'b1100 || w_mem_addr !== 32'h800) begin
        n_err++; $display("FAIL wd_wait k=%0d: got %b addr %h want 1100 800", k, {w_mem_req, w_StallM, w_MemErr, w_FillDone}, w_mem_addr); end
      @(posedge clk); @(negedge clk);
    end
    #1;
    n_cmp++; if ({w_MemErr, w_StallM, w_mem_req, w_FillDone, w_FillWE} !== 5'b10000) begin
      n_err++; $display("FAIL wd_abort: got %b want 10000", {w_MemErr, w_StallM, w_mem_req, w_FillDone, w_FillWE}); end
    ReqValid = 0;
    @(posedge clk); @(negedge clk);
    #1;
    n_cmp++; if ({w_MemErr, w_StallM, w_mem_req, w_FillDone} !== 4'b1000) begin
      n_err++; $display("FAIL wd_sticky: got %b want 1000", {w_MemErr, w_StallM, w_mem_req, w_FillDone}); end
    ReqValid = 1; Hit = 1;
    #1;
    n_cmp++; if (w_StallM !== 1'b0) begin
      n_err++; $display("FAIL wd_back_idle: got %b want 0", w_StallM); end
    ReqValid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 0; rst_n_wd = 0;
    idle_inputs();
    test_reset();
    test_load_hit();
    test_read_miss();
    test_store();
    test_backpressure();
    test_reset_midfill();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
